// File: rtl/saturn_debug_trace_tx_if.sv
// Debugger-side bundle feeding the trace transmitter: capture strobe, cycle counter
// and decoded-instruction fields, plus the transmitter's FSM state for observation.
interface saturn_debug_trace_tx_if;
    logic [31:0] i_cycle_ctr;
    logic        i_debug_cycle;
    logic [4:0]  i_alu_reg_dest;
    logic [4:0]  i_alu_reg_src_1;
    logic [4:0]  i_alu_reg_src_2;
    logic [3:0]  i_alu_imm_value;
    logic [4:0]  i_alu_opcode;
    logic [3:0]  i_instr_type;
    logic [1:0]  fsm_state;

    // Strobe semantics: no ready path; a rising edge of i_debug_cycle is a capture
    // request that is either accepted (FSM idle or finishing) or counted as dropped.
    modport master (
        output i_cycle_ctr, i_debug_cycle, i_alu_reg_dest, i_alu_reg_src_1,
               i_alu_reg_src_2, i_alu_imm_value, i_alu_opcode, i_instr_type,
        input  fsm_state
    );
    modport slave (
        input  i_cycle_ctr, i_debug_cycle, i_alu_reg_dest, i_alu_reg_src_1,
               i_alu_reg_src_2, i_alu_imm_value, i_alu_opcode, i_instr_type,
        output fsm_state
    );
endinterface

// File: rtl/saturn_debug_trace_tx.sv
// Snapshots debugger-cycle fields on each strobe rising edge and sends them as an
// 11-byte UART 8N1 packet: A5, ctr[4 LSB first], dest, src1, src2, {type,imm}, op, xor.
module saturn_debug_trace_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    saturn_debug_trace_tx_if.slave  dbg,
    output logic                    o_tx,
    output logic                    o_busy,
    output logic [7:0]              o_drop_ctr
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t          state, state_d;
    logic [BW-1:0]   baud_cnt, baud_d;
    logic [2:0]      bit_idx, bit_d, bit_nxt;
    logic [3:0]      byte_idx, byte_d;
    logic            tx_d, busy_d;
    logic            dbg_q;
    logic            edge_det, bit_end, pkt_end, capture, drop_inc;

    logic [31:0]     ctr_q;
    logic [4:0]      dest_q, src1_q, src2_q, op_q;
    logic [3:0]      imm_q, type_q;
    logic [7:0]      csum_q, csum_in, cur_byte;

    assign edge_det = dbg.i_debug_cycle & ~dbg_q;
    assign bit_end  = (baud_cnt == BAUD_LAST);
    assign pkt_end  = (state == S_STOP) && bit_end && (byte_idx == 4'd10);
    // A strobe on the final stop-bit edge starts the next packet instead of dropping.
    assign capture  = edge_det && ((state == S_IDLE) || pkt_end);
    assign drop_inc = edge_det && !capture;
    assign bit_nxt  = bit_idx + 3'd1;
    assign dbg.fsm_state = state;

    assign csum_in = dbg.i_cycle_ctr[7:0] ^ dbg.i_cycle_ctr[15:8]
                   ^ dbg.i_cycle_ctr[23:16] ^ dbg.i_cycle_ctr[31:24]
                   ^ {3'b000, dbg.i_alu_reg_dest} ^ {3'b000, dbg.i_alu_reg_src_1}
                   ^ {3'b000, dbg.i_alu_reg_src_2}
                   ^ {dbg.i_instr_type, dbg.i_alu_imm_value}
                   ^ {3'b000, dbg.i_alu_opcode};

    always_comb begin
        cur_byte = 8'hA5;
        case (byte_idx)
            4'd1:    cur_byte = ctr_q[7:0];
            4'd2:    cur_byte = ctr_q[15:8];
            4'd3:    cur_byte = ctr_q[23:16];
            4'd4:    cur_byte = ctr_q[31:24];
            4'd5:    cur_byte = {3'b000, dest_q};
            4'd6:    cur_byte = {3'b000, src1_q};
            4'd7:    cur_byte = {3'b000, src2_q};
            4'd8:    cur_byte = {type_q, imm_q};
            4'd9:    cur_byte = {3'b000, op_q};
            4'd10:   cur_byte = csum_q;
            default: cur_byte = 8'hA5;
        endcase
    end

    always_comb begin
        state_d = state;
        baud_d  = baud_cnt;
        bit_d   = bit_idx;
        byte_d  = byte_idx;
        tx_d    = o_tx;
        busy_d  = o_busy;
        case (state)
            S_IDLE: begin
                if (capture) begin
                    state_d = S_START;
                    baud_d  = '0;
                    byte_d  = 4'd0;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    tx_d    = cur_byte[0];
                end else begin
                    baud_d = baud_cnt + BW'(1);
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_idx == 3'd7) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_nxt;
                        tx_d  = cur_byte[bit_nxt];
                    end
                end else begin
                    baud_d = baud_cnt + BW'(1);
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (byte_idx != 4'd10) begin
                        byte_d  = byte_idx + 4'd1;
                        state_d = S_START;
                        tx_d    = 1'b0;
                    end else if (capture) begin
                        byte_d  = 4'd0;
                        state_d = S_START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    baud_d = baud_cnt + BW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state      <= S_IDLE;
            baud_cnt   <= '0;
            bit_idx    <= 3'd0;
            byte_idx   <= 4'd0;
            o_tx       <= 1'b1;
            o_busy     <= 1'b0;
            o_drop_ctr <= 8'd0;
            dbg_q      <= 1'b0;
        end else begin
            state    <= state_d;
            baud_cnt <= baud_d;
            bit_idx  <= bit_d;
            byte_idx <= byte_d;
            o_tx     <= tx_d;
            o_busy   <= busy_d;
            dbg_q    <= dbg.i_debug_cycle;
            if (drop_inc && (o_drop_ctr != 8'hFF))
                o_drop_ctr <= o_drop_ctr + 8'd1;
        end
    end

    // Payload registers only change on an accepted capture, so no reset is needed.
    always_ff @(posedge i_clk) begin
        if (capture) begin
            ctr_q  <= dbg.i_cycle_ctr;
            dest_q <= dbg.i_alu_reg_dest;
            src1_q <= dbg.i_alu_reg_src_1;
            src2_q <= dbg.i_alu_reg_src_2;
            imm_q  <= dbg.i_alu_imm_value;
            type_q <= dbg.i_instr_type;
            op_q   <= dbg.i_alu_opcode;
            csum_q <= csum_in;
        end
    end
endmodule

// File: tb/tb_saturn_debug_trace_tx.sv
// Bench for saturn_debug_trace_tx: a UART monitor decodes the line into rx_q and each
// scenario compares it with bytes the packet model pushed into exp_q at capture time.
module tb_saturn_debug_trace_tx;
    localparam int CPB     = 4;
    localparam int CPB_SAT = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_a, busy_a, tx_b, busy_b;
    logic [7:0] drop_a, drop_b;

    saturn_debug_trace_tx_if bus_a ();
    saturn_debug_trace_tx_if bus_b ();

    saturn_debug_trace_tx #(.CLKS_PER_BIT(CPB)) u_dut (
        .i_clk(clk), .i_reset(rst), .dbg(bus_a),
        .o_tx(tx_a), .o_busy(busy_a), .o_drop_ctr(drop_a)
    );

    saturn_debug_trace_tx #(.CLKS_PER_BIT(CPB_SAT)) u_sat (
        .i_clk(clk), .i_reset(rst), .dbg(bus_b),
        .o_tx(tx_b), .o_busy(busy_b), .o_drop_ctr(drop_b)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] ctr;
        logic [4:0]  dest;
        logic [4:0]  src1;
        logic [4:0]  src2;
        logic [3:0]  imm;
        logic [3:0]  typ;
        logic [4:0]  op;
    } fields_t;

    logic [8:0] exp_q[$];
    logic [8:0] rx_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [7:0] base_byte(fields_t f, int i);
        case (i)
            0:       return 8'hA5;
            1:       return f.ctr[7:0];
            2:       return f.ctr[15:8];
            3:       return f.ctr[23:16];
            4:       return f.ctr[31:24];
            5:       return {3'b000, f.dest};
            6:       return {3'b000, f.src1};
            7:       return {3'b000, f.src2};
            8:       return {f.typ, f.imm};
            9:       return {3'b000, f.op};
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] model_byte(fields_t f, int i);
        logic [7:0] x;
        if (i != 10) return base_byte(f, i);
        x = 8'h00;
        for (int j = 1; j < 10; j++) x = x ^ base_byte(f, j);
        return x;
    endfunction

    // Line level for UART bit slot pos of a packet: slot 0 start, 1..8 data, 9 stop.
    function automatic logic model_bit(fields_t f, int pos);
        int b;
        int s;
        logic [7:0] v;
        b = pos / 10;
        s = pos % 10;
        if (s == 0) return 1'b0;
        if (s == 9) return 1'b1;
        v = model_byte(f, b);
        return v[s-1];
    endfunction

    function automatic fields_t rand_fields();
        fields_t f;
        f.ctr  = $urandom;
        f.dest = 5'($urandom_range(0, 31));
        f.src1 = 5'($urandom_range(0, 31));
        f.src2 = 5'($urandom_range(0, 31));
        f.imm  = 4'($urandom_range(0, 15));
        f.typ  = 4'($urandom_range(0, 15));
        f.op   = 5'($urandom_range(0, 31));
        return f;
    endfunction

    task automatic drive_a(fields_t f);
        bus_a.i_cycle_ctr     = f.ctr;
        bus_a.i_alu_reg_dest  = f.dest;
        bus_a.i_alu_reg_src_1 = f.src1;
        bus_a.i_alu_reg_src_2 = f.src2;
        bus_a.i_alu_imm_value = f.imm;
        bus_a.i_instr_type    = f.typ;
        bus_a.i_alu_opcode    = f.op;
    endtask

    task automatic push_expected(fields_t f);
        for (int i = 0; i < 11; i++) exp_q.push_back({1'b1, model_byte(f, i)});
    endtask

    // UART receiver: samples mid-bit on falling clock edges, pushes {stop, data}.
    logic [7:0] mon_byte;
    always begin
        @(negedge clk);
        if (!rst && tx_a === 1'b0) begin
            repeat (CPB + CPB / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                mon_byte[i] = tx_a;
                repeat (CPB) @(negedge clk);
            end
            rx_q.push_back({tx_a, mon_byte});
        end
    end

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++; if (tx_a !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b want 1", tx_a); end
        n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_a); end
        n_checks++; if (drop_a !== 8'd0) begin n_fail++; $display("FAIL reset_drop: got %0d want 0", drop_a); end
        n_checks++; if (bus_a.fsm_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", bus_a.fsm_state); end
        n_checks++; if (tx_b !== 1'b1 || drop_b !== 8'd0) begin n_fail++; $display("FAIL reset_sat: tx %b drop %0d want 1/0", tx_b, drop_b); end
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_basic();
        fields_t f;
        int busy_cnt = 0;
        int bit_err  = 0;
        logic exp_bit;
        logic [8:0] got, want;
        f.ctr = 32'h12345678; f.dest = 5'd5; f.src1 = 5'd3; f.src2 = 5'h1F;
        f.imm = 4'hA; f.typ = 4'h7; f.op = 5'h11;
        @(negedge clk);
        drive_a(f); push_expected(f);
        bus_a.i_debug_cycle = 1'b1;
        @(negedge clk);
        bus_a.i_debug_cycle = 1'b0;
        for (int k = 0; k < 470; k++) begin
            if (busy_a === 1'b1) busy_cnt++;
            exp_bit = (k < 110 * CPB) ? model_bit(f, k / CPB) : 1'b1;
            if (tx_a !== exp_bit) bit_err++;
            @(negedge clk);
        end
        n_checks++; if (busy_cnt != 110 * CPB) begin n_fail++; $display("FAIL basic_busy_len: got %0d want %0d", busy_cnt, 110 * CPB); end
        n_checks++; if (bit_err != 0) begin n_fail++; $display("FAIL basic_bit_timing: %0d clocks differ, want 0", bit_err); end
        for (int i = 0; i < 11; i++) begin
            n_checks++;
            if (rx_q.size() == 0 || exp_q.size() == 0) begin
                n_fail++; $display("FAIL basic_byte%0d: rx queued %0d exp queued %0d", i, rx_q.size(), exp_q.size());
            end else begin
                got = rx_q.pop_front(); want = exp_q.pop_front();
                if (got !== want) begin n_fail++; $display("FAIL basic_byte%0d: got %h want %h", i, got, want); end
            end
        end
        n_checks++; if (rx_q.size() != 0) begin n_fail++; $display("FAIL basic_extra: %0d extra bytes, want 0", rx_q.size()); end
    endtask

    task automatic test_overrun();
        fields_t f;
        int t = 0;
        logic [8:0] got, want;
        f = rand_fields();
        @(negedge clk);
        drive_a(f); push_expected(f);
        bus_a.i_debug_cycle = 1'b1;
        @(negedge clk);
        bus_a.i_debug_cycle = 1'b0;
        repeat (49) @(negedge clk);
        drive_a(rand_fields());
        bus_a.i_debug_cycle = 1'b1;
        @(negedge clk); bus_a.i_debug_cycle = 1'b0;
        @(negedge clk); bus_a.i_debug_cycle = 1'b1; drive_a(rand_fields());
        @(negedge clk); bus_a.i_debug_cycle = 1'b0;
        while (busy_a === 1'b1 && t < 1000) begin @(negedge clk); t++; end
        n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL overrun_busy_timeout: busy %b want 0", busy_a); end
        n_checks++; if (drop_a !== 8'd2) begin n_fail++; $display("FAIL overrun_drop: got %0d want 2", drop_a); end
        repeat (5) @(negedge clk);
        for (int i = 0; i < 11; i++) begin
            n_checks++;
            if (rx_q.size() == 0 || exp_q.size() == 0) begin
                n_fail++; $display("FAIL overrun_byte%0d: rx queued %0d exp queued %0d", i, rx_q.size(), exp_q.size());
            end else begin
                got = rx_q.pop_front(); want = exp_q.pop_front();
                if (got !== want) begin n_fail++; $display("FAIL overrun_byte%0d: got %h want %h", i, got, want); end
            end
        end
        repeat (200) @(negedge clk);
        n_checks++; if (rx_q.size() != 0 || busy_a !== 1'b0) begin
            n_fail++; $display("FAIL overrun_no_second: rx %0d busy %b want 0/0", rx_q.size(), busy_a);
        end
    endtask

    task automatic test_back_to_back();
        fields_t fa, fb;
        int bit_err  = 0;
        int busy_err = 0;
        logic exp_bit;
        logic [8:0] got, want;
        fa = rand_fields(); fb = rand_fields();
        @(negedge clk);
        drive_a(fa); push_expected(fa);
        bus_a.i_debug_cycle = 1'b1;
        @(negedge clk);
        bus_a.i_debug_cycle = 1'b0;
        for (int k = 0; k < 900; k++) begin
            if (k < 110 * CPB)      exp_bit = model_bit(fa, k / CPB);
            else if (k < 220 * CPB) exp_bit = model_bit(fb, (k - 110 * CPB) / CPB);
            else                    exp_bit = 1'b1;
            if (tx_a !== exp_bit) bit_err++;
            if (busy_a !== (k < 220 * CPB)) busy_err++;
            if (k == 110 * CPB - 1) begin
                drive_a(fb); push_expected(fb);
                bus_a.i_debug_cycle = 1'b1;
            end
            if (k == 110 * CPB) bus_a.i_debug_cycle = 1'b0;
            @(negedge clk);
        end
        n_checks++; if (bit_err != 0) begin n_fail++; $display("FAIL b2b_bit_timing: %0d clocks differ, want 0", bit_err); end
        n_checks++; if (busy_err != 0) begin n_fail++; $display("FAIL b2b_busy: %0d clocks differ, want 0", busy_err); end
        n_checks++; if (drop_a !== 8'd2) begin n_fail++; $display("FAIL b2b_drop: got %0d want 2", drop_a); end
        for (int i = 0; i < 22; i++) begin
            n_checks++;
            if (rx_q.size() == 0 || exp_q.size() == 0) begin
                n_fail++; $display("FAIL b2b_byte%0d: rx queued %0d exp queued %0d", i, rx_q.size(), exp_q.size());
            end else begin
                got = rx_q.pop_front(); want = exp_q.pop_front();
                if (got !== want) begin n_fail++; $display("FAIL b2b_byte%0d: got %h want %h", i, got, want); end
            end
        end
    endtask

    task automatic test_reset_mid_packet();
        fields_t f;
        int t = 0;
        logic [8:0] got, want;
        f = rand_fields();
        @(negedge clk);
        drive_a(f); push_expected(f);
        bus_a.i_debug_cycle = 1'b1;
        @(negedge clk);
        bus_a.i_debug_cycle = 1'b0;
        // Byte 3 data bits occupy clocks 124..155 after capture.
        repeat (130) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++; if (tx_a !== 1'b1) begin n_fail++; $display("FAIL midrst_tx: got %b want 1", tx_a); end
        n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", busy_a); end
        n_checks++; if (drop_a !== 8'd0) begin n_fail++; $display("FAIL midrst_drop: got %0d want 0", drop_a); end
        n_checks++; if (bus_a.fsm_state !== 2'd0) begin n_fail++; $display("FAIL midrst_state: got %0d want 0", bus_a.fsm_state); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        exp_q.delete();
        rx_q.delete();
        f = rand_fields();
        drive_a(f); push_expected(f);
        bus_a.i_debug_cycle = 1'b1;
        @(negedge clk);
        bus_a.i_debug_cycle = 1'b0;
        while (busy_a === 1'b1 && t < 1000) begin @(negedge clk); t++; end
        n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL midrst_busy_timeout: busy %b want 0", busy_a); end
        repeat (5) @(negedge clk);
        for (int i = 0; i < 11; i++) begin
            n_checks++;
            if (rx_q.size() == 0 || exp_q.size() == 0) begin
                n_fail++; $display("FAIL midrst_byte%0d: rx queued %0d exp queued %0d", i, rx_q.size(), exp_q.size());
            end else begin
                got = rx_q.pop_front(); want = exp_q.pop_front();
                if (got !== want) begin n_fail++; $display("FAIL midrst_byte%0d: got %h want %h", i, got, want); end
            end
        end
    endtask

    task automatic test_level_hold();
        fields_t f;
        logic [8:0] got, want;
        f = rand_fields();
        @(negedge clk);
        drive_a(f); push_expected(f);
        bus_a.i_debug_cycle = 1'b1;
        repeat (1000) @(negedge clk);
        bus_a.i_debug_cycle = 1'b0;
        repeat (20) @(negedge clk);
        for (int i = 0; i < 11; i++) begin
            n_checks++;
            if (rx_q.size() == 0 || exp_q.size() == 0) begin
                n_fail++; $display("FAIL hold_byte%0d: rx queued %0d exp queued %0d", i, rx_q.size(), exp_q.size());
            end else begin
                got = rx_q.pop_front(); want = exp_q.pop_front();
                if (got !== want) begin n_fail++; $display("FAIL hold_byte%0d: got %h want %h", i, got, want); end
            end
        end
        n_checks++; if (rx_q.size() != 0) begin n_fail++; $display("FAIL hold_one_packet: %0d extra bytes, want 0", rx_q.size()); end
        n_checks++; if (drop_a !== 8'd0) begin n_fail++; $display("FAIL hold_drop: got %0d want 0", drop_a); end
        n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL hold_busy: got %b want 0", busy_a); end
    endtask

    task automatic test_saturation();
        int t = 0;
        @(negedge clk);
        bus_b.i_debug_cycle = 1'b1;
        @(negedge clk);
        bus_b.i_debug_cycle = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk); bus_b.i_debug_cycle = 1'b1;
            @(negedge clk); bus_b.i_debug_cycle = 1'b0;
        end
        @(negedge clk);
        n_checks++; if (drop_b !== 8'd255) begin n_fail++; $display("FAIL sat_drop: got %0d want 255", drop_b); end
        n_checks++; if (busy_b !== 1'b1) begin n_fail++; $display("FAIL sat_busy: got %b want 1", busy_b); end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); bus_b.i_debug_cycle = 1'b1;
            @(negedge clk); bus_b.i_debug_cycle = 1'b0;
        end
        @(negedge clk);
        n_checks++; if (drop_b !== 8'd255) begin n_fail++; $display("FAIL sat_hold: got %0d want 255", drop_b); end
        while (busy_b === 1'b1 && t < 10000) begin @(negedge clk); t++; end
        n_checks++; if (busy_b !== 1'b0) begin n_fail++; $display("FAIL sat_busy_timeout: busy %b want 0", busy_b); end
        n_checks++; if (drop_b !== 8'd255) begin n_fail++; $display("FAIL sat_end: got %0d want 255", drop_b); end
    endtask

    initial begin
        bus_a.i_debug_cycle = 1'b0;
        bus_b.i_debug_cycle = 1'b0;
        bus_b.i_cycle_ctr = 32'h0; bus_b.i_alu_reg_dest = 5'd0; bus_b.i_alu_reg_src_1 = 5'd0;
        bus_b.i_alu_reg_src_2 = 5'd0; bus_b.i_alu_imm_value = 4'd0; bus_b.i_alu_opcode = 5'd0;
        bus_b.i_instr_type = 4'd0;
        drive_a('0);
        test_reset();
        test_basic();
        test_overrun();
        test_back_to_back();
        test_reset_mid_packet();
        test_level_hold();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/saturn_debug_trace_tx.md
Name: saturn_debug_trace_tx

Overview:
- Consumer end of the debugger cycle interface.
- Watches `i_debug_cycle`. On each rising edge it snapshots the decoded-instruction fields and the cycle counter, then ships them off-chip as a fixed 11-byte packet on a UART 8N1 serial line.
- Sits beside the debugger and control unit, and drives the board trace pin.
- Snapshots arriving while a packet is still in flight are counted and discarded.

Parameters:
- `CLKS_PER_BIT`, default 16: `i_clk` cycles per UART bit. Legal range is ≥ 2.

Ports:
- `i_clk` input 1: single clock, all logic on the posedge.
- `i_reset` input 1: asynchronous, active-high reset.
- `i_cycle_ctr` input 32: core cycle counter, sampled at capture.
- `i_debug_cycle` input 1: debugger cycle strobe. Its rising edge triggers a capture.
- `i_alu_reg_dest` input 5: ALU destination register code.
- `i_alu_reg_src_1` input 5: ALU source 1 code.
- `i_alu_reg_src_2` input 5: ALU source 2 code.
- `i_alu_imm_value` input 4: immediate nibble.
- `i_alu_opcode` input 5: ALU opcode.
- `i_instr_type` input 4: instruction type.
- `o_tx` output 1: UART serial out. Idle level is 1.
- `o_busy` output 1: high while a packet is in flight.
- `o_drop_ctr` output 8: saturating count of dropped snapshots.

Behaviour:
- **Reset values** (applied asynchronously):
  - `o_tx`=1, `o_busy`=0, `o_drop_ctr`=0.
  - State=IDLE, bit/byte/baud counters=0.
  - Registered previous-strobe flag `dbg_q`=0.
- **Reset mid-packet:** line returns to 1 immediately and the packet is abandoned, with no completion of the current byte.
- **Edge detection:**
  - `edge` = `i_debug_cycle` & ~`dbg_q`.
  - `dbg_q` <= `i_debug_cycle` every clock.
  - If `i_debug_cycle` is high when reset releases, the first clock is treated as an edge.
- **Capture:** on a clock edge where `edge`=1 and the FSM is IDLE:
  - Latch all fields into a packet buffer.
  - Compute the checksum.
  - State <= START, `o_busy` <= 1, `o_tx` <= 0, byte index <= 0.
- **Packet byte order:**
  - byte 0: 0xA5 (sync).
  - bytes 1-4: `i_cycle_ctr`, LSB first.
  - byte 5: {3'b0, dest}.
  - byte 6: {3'b0, src1}.
  - byte 7: {3'b0, src2}.
  - byte 8: {type, imm}, with type in the high nibble.
  - byte 9: {3'b0, opcode}.
  - byte 10: XOR of bytes 1..9.
- **FSM states:**
  - IDLE: `o_tx`=1.
  - START: `o_tx`=0 for `CLKS_PER_BIT` clocks.
  - DATA: 8 bits, LSB first, each held `CLKS_PER_BIT` clocks.
  - STOP: `o_tx`=1 for `CLKS_PER_BIT` clocks.
    - After STOP, if byte index < 10: increment the index and go to START with no idle gap.
    - Otherwise go to IDLE and set `o_busy` <= 0 on that same edge.
- **Timing:**
  - Every bit lasts exactly `CLKS_PER_BIT` clocks.
  - A packet lasts 110×`CLKS_PER_BIT` clocks from the capture edge to the `o_busy` fall.
  - Latency is 0: `o_tx` falls at the capture edge.
- **Overrun:**
  - If `edge`=1 while the FSM is not IDLE, the snapshot is ignored.
  - `o_drop_ctr` increments, saturating at 255.
  - The in-flight packet is unaffected.
- **Simultaneous end and edge:** if `edge` coincides with the edge that ends the last STOP bit, it is accepted as a new capture, not dropped. The FSM goes directly to START and `o_busy` stays 1.
- **Input stability:** inputs are sampled only at capture. Changes during transmission do not affect the packet.

Test Plan:
- **Basic packet:** `CLKS_PER_BIT`=4; ctr=0x12345678, dest=5, src1=3, src2=0x1F, imm=0xA, type=0x7, opcode=0x11; pulse `i_debug_cycle`.
  - UART monitor decodes A5 78 56 34 12 05 03 1F 7A 11 7A.
  - `o_busy` is high exactly 440 clocks.
  - Each bit is 4 clocks.
- **Overrun:** two more rising edges 50 clocks after the first capture.
  - `o_drop_ctr`=2.
  - First packet bytes are unchanged.
  - No second packet is sent.
- **Back-to-back:** raise `i_debug_cycle` on the exact edge the last stop bit ends.
  - Second packet starts with no idle clock and `o_busy` never drops.
  - `o_drop_ctr` is unchanged.
- **Level hold:** hold `i_debug_cycle` high for 1000 clocks.
  - Exactly one packet is sent.
  - `o_drop_ctr`=0.
- **Saturation:** 300 rising edges during one packet (`CLKS_PER_BIT`=64).
  - `o_drop_ctr`=255 and stays 255.
- **Reset mid-packet:** assert `i_reset` asynchronously during byte 3's data bits.
  - `o_tx`=1, `o_busy`=0 and `o_drop_ctr`=0 before the next clock edge.
  - After release, a new edge produces a complete, correct packet.
